// File: rtl/sha2_msg_scheduler.sv
// SHA-2 message scheduler: accepts a 16-word block and streams W[0..ROUNDS-1]
// over a valid/ready interface, expanding words in place in a 16-slot ring.
module sha2_msg_scheduler #(
  parameter int WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [16*WORD_W-1:0]  blk_data,
  input  logic                  abort,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [WORD_W-1:0]     w_out,
  output logic [6:0]            w_idx,
  output logic                  w_last,
  output logic                  busy
);

  localparam int         ROUNDS = (WORD_W == 64) ? 80 : 64;
  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  generate
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
      $error("sha2_msg_scheduler: WORD_W must be 32 or 64");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [6:0]        t_q, t_d;
  logic [WORD_W-1:0] buf_q [16];

  logic              load, beat, expand;
  logic [3:0]        slot, slot_m1, slot_m6, slot_m14, slot_m15;
  logic [WORD_W-1:0] w_new;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    if (WORD_W == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    else              return rotr(x, 1) ^ rotr(x, 8)  ^ (x >> 7);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    if (WORD_W == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    else              return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  // Ring-buffer addressing: t-15 and t+1 share a slot, so W[t+1] overwrites W[t-15].
  always_comb begin
    slot     = t_q[3:0];
    slot_m1  = slot - 4'd1;
    slot_m6  = slot - 4'd6;
    slot_m14 = slot + 4'd2;
    slot_m15 = slot + 4'd1;
    w_new    = sigma1(buf_q[slot_m1]) + buf_q[slot_m6]
             + sigma0(buf_q[slot_m14]) + buf_q[slot_m15];
  end

  // Abort outranks both a load and a word beat.
  always_comb begin
    load    = (state_q == IDLE) && blk_valid && !abort;
    beat    = (state_q == RUN) && w_ready && !abort;
    expand  = beat && (t_q >= 7'd15) && (t_q != LAST_T);
    state_d = state_q;
    t_d     = t_q;
    if (abort) begin
      state_d = IDLE;
      t_d     = '0;
    end else if (load) begin
      state_d = RUN;
      t_d     = '0;
    end else if (beat) begin
      if (t_q == LAST_T) begin
        state_d = IDLE;
        t_d     = '0;
      end else begin
        t_d = t_q + 7'd1;
      end
    end
  end

  // Register stage: control state and round counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  // Register stage: word storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) buf_q[i] <= blk_data[(15-i)*WORD_W +: WORD_W];
    end else if (expand) begin
      buf_q[slot_m15] <= w_new;
    end
  end

  always_comb begin
    busy      = (state_q == RUN);
    w_valid   = busy;
    blk_ready = !busy;
    w_out     = busy ? buf_q[slot] : '0;
    w_idx     = busy ? t_q : '0;
    w_last    = busy && (t_q == LAST_T);
  end

endmodule

// File: tb/tb_sha2_msg_scheduler.sv
// Self-checking bench for sha2_msg_scheduler: a full-array SHA-2 expansion model
// is compared against 32-bit and 64-bit instances on every cycle.
module tb_sha2_msg_scheduler;

  logic clk;
  logic rst_n;

  logic          blk_valid32, blk_ready32, abort32, w_valid32, w_ready32, w_last32, busy32;
  logic [511:0]  blk_data32;
  logic [31:0]   w_out32;
  logic [6:0]    w_idx32;

  logic          blk_valid64, blk_ready64, abort64, w_valid64, w_ready64, w_last64, busy64;
  logic [1023:0] blk_data64;
  logic [63:0]   w_out64;
  logic [6:0]    w_idx64;

  int checks = 0;
  int errors = 0;
  bit done   = 0;

  sha2_msg_scheduler #(.WORD_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid32), .blk_ready(blk_ready32),
    .blk_data(blk_data32), .abort(abort32), .w_valid(w_valid32), .w_ready(w_ready32),
    .w_out(w_out32), .w_idx(w_idx32), .w_last(w_last32), .busy(busy32));

  sha2_msg_scheduler #(.WORD_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid64), .blk_ready(blk_ready64),
    .blk_data(blk_data64), .abort(abort64), .w_valid(w_valid64), .w_ready(w_ready64),
    .w_out(w_out64), .w_idx(w_idx64), .w_last(w_last64), .busy(busy64));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int ww);
    logic [63:0] m;
    m = (ww == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    return ((x >> n) | (x << (ww - n))) & m;
  endfunction

  function automatic logic [63:0] ssig0(input logic [63:0] x, input int ww);
    if (ww == 32) return rotr(x, 7, ww) ^ rotr(x, 18, ww) ^ (x >> 3);
    return rotr(x, 1, ww) ^ rotr(x, 8, ww) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] ssig1(input logic [63:0] x, input int ww);
    if (ww == 32) return rotr(x, 17, ww) ^ rotr(x, 19, ww) ^ (x >> 10);
    return rotr(x, 19, ww) ^ rotr(x, 61, ww) ^ (x >> 6);
  endfunction

  // Textbook schedule: expand the whole W array, then pick word t.
  function automatic logic [63:0] sched(input logic [1023:0] blk, input int ww, input int t);
    logic [63:0] w [80];
    logic [63:0] m;
    m = (ww == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int i = 0; i < 16; i++) w[i] = 64'(blk >> ((15 - i) * ww)) & m;
    for (int i = 16; i < 80; i++)
      w[i] = (ssig1(w[i-2], ww) + w[i-7] + ssig0(w[i-15], ww) + w[i-16]) & m;
    return w[t];
  endfunction

  // Transaction-level reference: is a block streaming, which word is due, which block.
  bit            m32_run = 0, m64_run = 0;
  int            m32_t = 0, m64_t = 0;
  logic [1023:0] m32_blk = '0, m64_blk = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m32_run <= 0; m32_t <= 0;
    end else if (abort32) begin
      m32_run <= 0; m32_t <= 0;
    end else if (!m32_run) begin
      if (blk_valid32) begin m32_run <= 1; m32_t <= 0; m32_blk <= 1024'(blk_data32); end
    end else if (w_ready32) begin
      if (m32_t == 63) begin m32_run <= 0; m32_t <= 0; end
      else m32_t <= m32_t + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m64_run <= 0; m64_t <= 0;
    end else if (abort64) begin
      m64_run <= 0; m64_t <= 0;
    end else if (!m64_run) begin
      if (blk_valid64) begin m64_run <= 1; m64_t <= 0; m64_blk <= blk_data64; end
    end else if (w_ready64) begin
      if (m64_t == 79) begin m64_run <= 0; m64_t <= 0; end
      else m64_t <= m64_t + 1;
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      check("w32_valid", 64'(w_valid32), 64'(m32_run));
      check("w32_blk_ready", 64'(blk_ready32), 64'(!m32_run));
      check("w32_busy", 64'(busy32), 64'(m32_run));
      check("w32_idx", 64'(w_idx32), m32_run ? 64'(m32_t) : 64'd0);
      check("w32_out", 64'(w_out32), m32_run ? sched(m32_blk, 32, m32_t) : 64'd0);
      check("w32_last", 64'(w_last32), 64'(m32_run && m32_t == 63));
      check("w64_valid", 64'(w_valid64), 64'(m64_run));
      check("w64_blk_ready", 64'(blk_ready64), 64'(!m64_run));
      check("w64_busy", 64'(busy64), 64'(m64_run));
      check("w64_idx", 64'(w_idx64), m64_run ? 64'(m64_t) : 64'd0);
      check("w64_out", w_out64, m64_run ? sched(m64_blk, 64, m64_t) : 64'd0);
      check("w64_last", 64'(w_last64), 64'(m64_run && m64_t == 79));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic rnd(input int duty);
    return int'($urandom_range(0, 99)) < duty;
  endfunction

  function automatic logic [511:0] rand_blk32();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [1023:0] rand_blk64();
    logic [1023:0] b;
    for (int i = 0; i < 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Loads one block (scheduler must be idle) and drains it; n = edges from load to blk_ready.
  task automatic run32(input logic [511:0] blk, input int duty, output int n);
    blk_data32 = blk; blk_valid32 = 1'b1; w_ready32 = rnd(duty);
    tick();
    blk_valid32 = 1'b0; n = 0;
    while (!blk_ready32 && n < 2000) begin w_ready32 = rnd(duty); tick(); n++; end
    if (!blk_ready32) check("run32_timeout", 64'd0, 64'd1);
  endtask

  task automatic run64(input logic [1023:0] blk, input int duty, output int n);
    blk_data64 = blk; blk_valid64 = 1'b1; w_ready64 = rnd(duty);
    tick();
    blk_valid64 = 1'b0; n = 0;
    while (!blk_ready64 && n < 2000) begin w_ready64 = rnd(duty); tick(); n++; end
    if (!blk_ready64) check("run64_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idx32(input int target, input int duty);
    int k = 0;
    while (!(w_valid32 && int'(w_idx32) == target) && k < 1000) begin
      w_ready32 = rnd(duty); tick(); k++;
    end
    if (k >= 1000) check("wait_idx32_timeout", 64'd0, 64'd1);
  endtask

  logic [511:0]  abc32;
  logic [1023:0] abc64;
  int n, cnt;
  bit seen_idle;

  initial begin
    rst_n = 1'b0;
    blk_valid32 = 0; abort32 = 0; w_ready32 = 0; blk_data32 = '0;
    blk_valid64 = 0; abort64 = 0; w_ready64 = 0; blk_data64 = '0;
    abc32 = {32'h6162_6380, 448'd0, 32'h0000_0018};
    abc64 = {64'h6162_6380_0000_0000, 896'd0, 64'h0000_0000_0000_0018};
    #1;
    check("rst_blk_ready", 64'(blk_ready32), 64'd1);
    check("rst_w_valid", 64'(w_valid32), 64'd0);
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_w_last", 64'(w_last32), 64'd0);
    check("rst_w_out", 64'(w_out32), 64'd0);
    check("rst_w_idx", 64'(w_idx32), 64'd0);

    // Hand-computed anchors for the model
    check("model_w0", sched(1024'(abc32), 32, 0), 64'h6162_6380);
    check("model_w15", sched(1024'(abc32), 32, 15), 64'h0000_0018);
    check("model_w16", sched(1024'(abc32), 32, 16), 64'h6162_6380);
    check("model_w17", sched(1024'(abc32), 32, 17), 64'h000F_0000);
    check("model64_w16", sched(abc64, 64, 16), 64'h6162_6380_0000_0000);

    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // SHA-256 and SHA-512 "abc" at full rate
    run32(abc32, 100, n);
    check("abc32_next_load_edge", 64'(n + 1), 64'd65);
    run64(abc64, 100, n);
    check("abc64_next_load_edge", 64'(n + 1), 64'd81);

    // Back-pressure on both widths
    run32(rand_blk32(), 30, n);
    run32(abc32, 30, n);
    run64(rand_blk64(), 30, n);

    // Back-to-back: blk_valid held high, data swapped once the first block is running
    blk_data32 = rand_blk32(); blk_valid32 = 1'b1; w_ready32 = 1'b1;
    tick();
    blk_data32 = rand_blk32();
    cnt = 0; seen_idle = 0;
    while (cnt < 200) begin
      tick(); cnt++;
      if (seen_idle && busy32) break;
      if (blk_ready32) seen_idle = 1;
    end
    check("b2b_load_spacing", 64'(cnt), 64'd65);
    blk_valid32 = 1'b0;
    cnt = 0;
    while (!blk_ready32 && cnt < 200) begin tick(); cnt++; end
    check("b2b_second_done", 64'(blk_ready32), 64'd1);

    // Abort at word 20, colliding with a new block offer
    blk_data32 = rand_blk32(); blk_valid32 = 1'b1; w_ready32 = 1'b1;
    tick();
    blk_valid32 = 1'b0;
    wait_idx32(20, 70);
    abort32 = 1'b1; blk_valid32 = 1'b1; blk_data32 = rand_blk32(); w_ready32 = 1'b1;
    tick();
    abort32 = 1'b0; blk_valid32 = 1'b0;
    check("abort_w_valid", 64'(w_valid32), 64'd0);
    check("abort_blk_ready", 64'(blk_ready32), 64'd1);
    check("abort_busy", 64'(busy32), 64'd0);
    run32(rand_blk32(), 60, n);

    // Asynchronous reset in the middle of a block
    blk_data32 = rand_blk32(); blk_valid32 = 1'b1; w_ready32 = 1'b1;
    tick();
    blk_valid32 = 1'b0;
    wait_idx32(40, 100);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_w_valid", 64'(w_valid32), 64'd0);
    check("midrst_busy", 64'(busy32), 64'd0);
    check("midrst_blk_ready", 64'(blk_ready32), 64'd1);
    check("midrst_w_out", 64'(w_out32), 64'd0);
    check("midrst_w_idx", 64'(w_idx32), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run32(rand_blk32(), 100, n);
    check("post_rst_next_load_edge", 64'(n + 1), 64'd65);
    run64(abc64, 50, n);

    tick();
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
